// File: rtl/pipeline_ctrl.sv
// ============================================================================
// pipeline_ctrl
// ----------------------------------------------------------------------------
// Hazard and stall controller for a five-stage pipeline. It decides each cycle
// whether the pipeline can advance, taking into account instruction and data
// memory hits (which may arrive in different cycles), load-use hazards and
// control-flow redirects. It also tracks a sticky halt and counts stall cycles.
//
// Ports
//   CLK              in   1  rising-edge clock
//   RST              in   1  asynchronous active-high reset
//   ihit             in   1  instruction memory hit
//   dhit             in   1  data memory hit
//   mem_dREN         in   1  MEM-stage load request
//   mem_dWEN         in   1  MEM-stage store request
//   ex_dREN          in   1  EX-stage instruction is a load
//   ex_regDst        in   5  EX-stage destination register
//   id_rs            in   5  ID-stage source register
//   id_rt            in   5  ID-stage source register
//   ex_branch_taken  in   1  EX-stage branch resolved taken
//   ex_jump          in   1  EX-stage jump
//   mem_halt         in   1  halt instruction in MEM
//   pc_en            out  1  PC update enable
//   ifid_en          out  1  IF/ID latch enable
//   idex_en          out  1  ID/EX latch enable
//   exmem_en         out  1  EX/MEM latch enable
//   memwb_en         out  1  MEM/WB latch enable
//   ifid_flush       out  1  clear IF/ID
//   idex_flush       out  1  clear ID/EX
//   halt             out  1  sticky halted flag
//   stall_cnt        out 16  stalled-cycle counter (saturating)
// ============================================================================
module pipeline_ctrl (
    input  logic        CLK,
    input  logic        RST,
    input  logic        ihit,
    input  logic        dhit,
    input  logic        mem_dREN,
    input  logic        mem_dWEN,
    input  logic        ex_dREN,
    input  logic [4:0]  ex_regDst,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        ex_branch_taken,
    input  logic        ex_jump,
    input  logic        mem_halt,
    output logic        pc_en,
    output logic        ifid_en,
    output logic        idex_en,
    output logic        exmem_en,
    output logic        memwb_en,
    output logic        ifid_flush,
    output logic        idex_flush,
    output logic        halt,
    output logic [15:0] stall_cnt
);

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        WAIT = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t state;

    // Remember a hit that arrived while the other memory was still busy, so
    // the pipeline can advance once both sides have completed.
    logic ih_l;
    logic dh_l;

    logic memop;
    logic adv;
    logic luh;
    logic redir;
    logic active;
    logic stall;

    assign memop  = mem_dREN | mem_dWEN;
    assign adv    = (ihit | ih_l) & (~memop | dhit | dh_l);
    // Register 0 is hardwired to zero, so a load into it never creates a hazard.
    assign luh    = ex_dREN & (ex_regDst != 5'd0) &
                    ((ex_regDst == id_rs) | (ex_regDst == id_rt));
    assign redir  = ex_branch_taken | ex_jump;
    assign active = (state != HALT);
    // A load-use bubble counts as a stall; a redirect squashes the dependent
    // instruction, so it does not.
    assign stall  = active & (~adv | (~redir & luh));
    assign halt   = (state == HALT);

    // Enables and flushes are combinational so a stall takes effect in the
    // same cycle the condition is seen.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves one
        // unassigned, which would otherwise infer a latch.
        pc_en      = 1'b0;
        ifid_en    = 1'b0;
        idex_en    = 1'b0;
        exmem_en   = 1'b0;
        memwb_en   = 1'b0;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;
        if (active && adv) begin
            idex_en  = 1'b1;
            exmem_en = 1'b1;
            memwb_en = 1'b1;
            if (redir) begin
                // Redirect wins over load-use: the dependent instruction is
                // squashed anyway, so there is nothing to wait for.
                pc_en      = 1'b1;
                ifid_en    = 1'b1;
                ifid_flush = 1'b1;
                idex_flush = 1'b1;
            end else if (luh) begin
                // Hold PC and IF/ID, inject a bubble into ID/EX.
                idex_flush = 1'b1;
            end else begin
                pc_en   = 1'b1;
                ifid_en = 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= RUN;
            ih_l      <= 1'b0;
            dh_l      <= 1'b0;
            stall_cnt <= 16'd0;
        end else begin
            case (state)
                RUN, WAIT: begin
                    if (adv) begin
                        ih_l  <= 1'b0;
                        dh_l  <= 1'b0;
                        state <= mem_halt ? HALT : RUN;
                    end else begin
                        ih_l  <= ih_l | ihit;
                        dh_l  <= dh_l | dhit;
                        state <= WAIT;
                    end
                    if (stall && (stall_cnt != 16'hFFFF)) begin
                        stall_cnt <= stall_cnt + 16'd1;
                    end
                end
                HALT: begin
                    // Only RST leaves HALT; everything holds.
                    state <= HALT;
                end
                default: begin
                    state <= RUN;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// ============================================================================
// tb_pipeline_ctrl
// ----------------------------------------------------------------------------
// Directed self-checking bench for pipeline_ctrl. Inputs change 1 ns after a
// rising edge; combinational outputs are sampled 2 ns after the edge and the
// registered stall counter 1 ns after the following edge.
// ============================================================================
module tb_pipeline_ctrl;

    logic        CLK;
    logic        RST;
    logic        ihit;
    logic        dhit;
    logic        mem_dREN;
    logic        mem_dWEN;
    logic        ex_dREN;
    logic [4:0]  ex_regDst;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic        ex_branch_taken;
    logic        ex_jump;
    logic        mem_halt;
    logic        pc_en;
    logic        ifid_en;
    logic        idex_en;
    logic        exmem_en;
    logic        memwb_en;
    logic        ifid_flush;
    logic        idex_flush;
    logic        halt;
    logic [15:0] stall_cnt;

    int checks   = 0;
    int failures = 0;
    int exp_stall = 0;

    pipeline_ctrl dut (
        .CLK             (CLK),
        .RST             (RST),
        .ihit            (ihit),
        .dhit            (dhit),
        .mem_dREN        (mem_dREN),
        .mem_dWEN        (mem_dWEN),
        .ex_dREN         (ex_dREN),
        .ex_regDst       (ex_regDst),
        .id_rs           (id_rs),
        .id_rt           (id_rt),
        .ex_branch_taken (ex_branch_taken),
        .ex_jump         (ex_jump),
        .mem_halt        (mem_halt),
        .pc_en           (pc_en),
        .ifid_en         (ifid_en),
        .idex_en         (idex_en),
        .exmem_en        (exmem_en),
        .memwb_en        (memwb_en),
        .ifid_flush      (ifid_flush),
        .idex_flush      (idex_flush),
        .halt            (halt),
        .stall_cnt       (stall_cnt)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // One directed cycle: drive inputs, check the combinational outputs, clock,
    // then check the stall counter against the running expectation.
    task automatic cyc(input string tag,
                       input logic ih, input logic dh, input logic mr, input logic mw,
                       input logic exr, input logic [4:0] dst, input logic [4:0] rs, input logic [4:0] rt,
                       input logic br, input logic jp, input logic mh,
                       input logic [4:0] exp_en, input logic [1:0] exp_fl,
                       input logic exp_h, input logic inc);
        ihit            = ih;
        dhit            = dh;
        mem_dREN        = mr;
        mem_dWEN        = mw;
        ex_dREN         = exr;
        ex_regDst       = dst;
        id_rs           = rs;
        id_rt           = rt;
        ex_branch_taken = br;
        ex_jump         = jp;
        mem_halt        = mh;
        #1;
        check({tag, ".en"}, {27'd0, pc_en, ifid_en, idex_en, exmem_en, memwb_en}, {27'd0, exp_en});
        check({tag, ".flush"}, {30'd0, ifid_flush, idex_flush}, {30'd0, exp_fl});
        check({tag, ".halt"}, {31'd0, halt}, {31'd0, exp_h});
        @(posedge CLK);
        #1;
        if (inc) exp_stall++;
        check({tag, ".stall_cnt"}, {16'd0, stall_cnt}, exp_stall);
    endtask

    task automatic clear_inputs();
        ihit = 0; dhit = 0; mem_dREN = 0; mem_dWEN = 0; ex_dREN = 0;
        ex_regDst = 0; id_rs = 0; id_rt = 0; ex_branch_taken = 0; ex_jump = 0; mem_halt = 0;
    endtask

    initial begin
        clear_inputs();
        RST = 1'b1;
        @(posedge CLK);
        #1;
        // Reset state: enables low with ihit=0, counters and halt cleared.
        check("rst.en", {27'd0, pc_en, ifid_en, idex_en, exmem_en, memwb_en}, 32'd0);
        check("rst.flush", {30'd0, ifid_flush, idex_flush}, 32'd0);
        check("rst.halt", {31'd0, halt}, 32'd0);
        check("rst.stall_cnt", {16'd0, stall_cnt}, 32'd0);
        RST = 1'b0;

        // Free-running pipeline: every cycle advances, no stalls.
        for (int i = 0; i < 10; i++)
            cyc("run", 1,0,0,0, 0,5'd0,5'd0,5'd0, 0,0,0, 5'b11111, 2'b00, 0, 0);

        // Data-memory miss: ihit early, dhit three cycles later.
        cyc("miss_c0",  1,0,1,0, 0,5'd0,5'd0,5'd0, 0,0,0, 5'b00000, 2'b00, 0, 1);
        cyc("miss_c1",  0,0,1,0, 0,5'd0,5'd0,5'd0, 0,0,0, 5'b00000, 2'b00, 0, 1);
        cyc("miss_c2",  0,0,1,0, 0,5'd0,5'd0,5'd0, 0,0,0, 5'b00000, 2'b00, 0, 1);
        cyc("miss_c3",  0,1,1,0, 0,5'd0,5'd0,5'd0, 0,0,0, 5'b11111, 2'b00, 0, 0);
        // ih_l must be clear now: no ihit, no memop -> no advance.
        cyc("ihl_clr",  0,0,0,0, 0,5'd0,5'd0,5'd0, 0,0,0, 5'b00000, 2'b00, 0, 1);

        // Simultaneous hits advance at once and leave both latches clear.
        cyc("both_hit", 1,1,1,0, 0,5'd0,5'd0,5'd0, 0,0,0, 5'b11111, 2'b00, 0, 0);
        cyc("both_clr", 0,0,1,0, 0,5'd0,5'd0,5'd0, 0,0,0, 5'b00000, 2'b00, 0, 1);

        // dhit early, repeated while latched, then ihit completes the pair.
        cyc("dh_set",   0,1,1,0, 0,5'd0,5'd0,5'd0, 0,0,0, 5'b00000, 2'b00, 0, 1);
        cyc("dh_again", 0,1,1,0, 0,5'd0,5'd0,5'd0, 0,0,0, 5'b00000, 2'b00, 0, 1);
        cyc("dh_use",   1,0,1,0, 0,5'd0,5'd0,5'd0, 0,0,0, 5'b11111, 2'b00, 0, 0);
        cyc("dh_clr",   1,0,1,0, 0,5'd0,5'd0,5'd0, 0,0,0, 5'b00000, 2'b00, 0, 1);
        cyc("store_hit",1,1,0,1, 0,5'd0,5'd0,5'd0, 0,0,0, 5'b11111, 2'b00, 0, 0);

        // Load-use hazards on rt and rs; r0 and non-matching cases do not stall.
        cyc("luh_rt",   1,0,0,0, 1,5'd5,5'd0,5'd5, 0,0,0, 5'b00111, 2'b01, 0, 1);
        cyc("luh_rs",   1,0,0,0, 1,5'd7,5'd7,5'd0, 0,0,0, 5'b00111, 2'b01, 0, 1);
        cyc("luh_r0",   1,0,0,0, 1,5'd0,5'd0,5'd0, 0,0,0, 5'b11111, 2'b00, 0, 0);
        cyc("no_match", 1,0,0,0, 1,5'd5,5'd3,5'd4, 0,0,0, 5'b11111, 2'b00, 0, 0);
        cyc("not_load", 1,0,0,0, 0,5'd5,5'd0,5'd5, 0,0,0, 5'b11111, 2'b00, 0, 0);

        // Redirect beats load-use; redirect without advance still stalls.
        cyc("luh_br",   1,0,0,0, 1,5'd5,5'd0,5'd5, 1,0,0, 5'b11111, 2'b11, 0, 0);
        cyc("jump",     1,0,0,0, 0,5'd0,5'd0,5'd0, 0,1,0, 5'b11111, 2'b11, 0, 0);
        cyc("br_miss",  0,0,0,0, 0,5'd0,5'd0,5'd0, 1,0,0, 5'b00000, 2'b00, 0, 1);
        cyc("br_recov", 1,0,0,0, 0,5'd0,5'd0,5'd0, 0,0,0, 5'b11111, 2'b00, 0, 0);

        // Reset mid-WAIT with ih_l set: the latch must be discarded at once.
        cyc("wait_set", 1,0,1,0, 0,5'd0,5'd0,5'd0, 0,0,0, 5'b00000, 2'b00, 0, 1);
        clear_inputs();
        RST = 1'b1;
        #1;
        check("rst_wait.en", {27'd0, pc_en, ifid_en, idex_en, exmem_en, memwb_en}, 32'd0);
        check("rst_wait.stall_cnt", {16'd0, stall_cnt}, 32'd0);
        @(posedge CLK);
        #1;
        RST = 1'b0;
        exp_stall = 0;
        cyc("post_rst", 0,0,0,0, 0,5'd0,5'd0,5'd0, 0,0,0, 5'b00000, 2'b00, 0, 1);

        // Halt: enters on advance with mem_halt, then freezes everything.
        cyc("halt_in",  1,0,0,0, 0,5'd0,5'd0,5'd0, 0,0,1, 5'b11111, 2'b00, 0, 0);
        cyc("halted1",  1,0,0,0, 0,5'd0,5'd0,5'd0, 0,0,0, 5'b00000, 2'b00, 1, 0);
        cyc("halted2",  0,0,1,0, 0,5'd0,5'd0,5'd0, 0,0,0, 5'b00000, 2'b00, 1, 0);
        cyc("halted3",  1,1,0,0, 1,5'd5,5'd5,5'd0, 1,0,0, 5'b00000, 2'b00, 1, 0);
        clear_inputs();
        RST = 1'b1;
        #1;
        check("rst_halt.halt", {31'd0, halt}, 32'd0);
        check("rst_halt.stall_cnt", {16'd0, stall_cnt}, 32'd0);
        @(posedge CLK);
        #1;
        RST = 1'b0;
        exp_stall = 0;
        cyc("after_rst", 1,0,0,0, 0,5'd0,5'd0,5'd0, 0,0,0, 5'b11111, 2'b00, 0, 0);

        // Saturation: 65534 stall cycles from zero, then 3 more.
        clear_inputs();
        repeat (65534) @(posedge CLK);
        #1;
        check("sat.fffe", {16'd0, stall_cnt}, 32'h0000FFFE);
        repeat (3) @(posedge CLK);
        #1;
        check("sat.ffff", {16'd0, stall_cnt}, 32'h0000FFFF);
        check("sat.en", {27'd0, pc_en, ifid_en, idex_en, exmem_en, memwb_en}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset: CLK in 1, rising-edge clock; RST in 1, active-high asynchronous reset.
REQ-002 Inputs SHALL be:
- ihit in 1: instruction memory hit
- dhit in 1: data memory hit
- mem_dREN in 1: MEM-stage load request
- mem_dWEN in 1: MEM-stage store request
- ex_dREN in 1: EX-stage instruction is a load
- ex_regDst in 5: EX-stage destination register
- id_rs in 5: ID-stage source register
- id_rt in 5: ID-stage source register
- ex_branch_taken in 1: EX-stage branch resolved taken
- ex_jump in 1: EX-stage jump
- mem_halt in 1: halt instruction in MEM
REQ-003 Outputs SHALL be:
- pc_en out 1: PC update enable
- ifid_en out 1: IF/ID latch enable
- idex_en out 1: ID/EX latch enable
- exmem_en out 1: EX/MEM latch enable
- memwb_en out 1: MEM/WB latch enable
- ifid_flush out 1: clear IF/ID
- idex_flush out 1: clear ID/EX
- halt out 1: sticky halted flag
- stall_cnt out 16: stalled-cycle counter

Function
REQ-004 The block SHALL implement FSM states RUN, WAIT and HALT.
REQ-005 The block SHALL keep hit latches ih_l and dh_l, each set on its hit input and cleared on any cycle where adv=1.
REQ-006 Definitions:
- memop = mem_dREN | mem_dWEN
- adv = (ihit | ih_l) & (!memop | dhit | dh_l)
REQ-007 Load-use hazard: luh = ex_dREN & (ex_regDst != 0) & (ex_regDst == id_rs | ex_regDst == id_rt).
REQ-008 Redirect: redir = ex_branch_taken | ex_jump.
REQ-009 In RUN or WAIT with adv=0, all enables and both flushes SHALL be 0, and the next state SHALL be WAIT.
REQ-010 In RUN or WAIT with adv=1 and redir=1, all enables SHALL be 1 and ifid_flush=idex_flush=1; redir SHALL take priority over luh.
REQ-011 In RUN or WAIT with adv=1, redir=0 and luh=1:
- pc_en=ifid_en=0
- idex_flush=1
- idex_en=exmem_en=memwb_en=1
REQ-012 In RUN or WAIT with adv=1, redir=0 and luh=0, all enables SHALL be 1 and both flushes 0.
REQ-013 In RUN or WAIT with adv=1, the next state SHALL be HALT if mem_halt=1, else RUN.
REQ-014 In HALT, all enables and flushes SHALL be 0 and halt=1; HALT SHALL be exited only by RST.
REQ-015 Enables and flushes SHALL be combinational from state, latches and inputs, with zero latency.
REQ-016 stall_cnt SHALL increment by 1 on each clock edge in RUN or WAIT where adv=0 or (adv=1 & redir=0 & luh=1), SHALL saturate at 0xFFFF, and SHALL hold in HALT.
REQ-017 Simultaneous ihit and dhit SHALL produce adv=1 in that same cycle and SHALL leave both latches clear.
REQ-018 A hit arriving while its latch is already set SHALL have no additional effect.

Reset
REQ-019 While RST=1, the state SHALL be RUN, ih_l=dh_l=0, stall_cnt=0 and halt=0.
REQ-020 Output values during RST=1 follow from REQ-019 and REQ-009: with ihit=0, all enables SHALL be 0.
REQ-021 Asserting RST mid-WAIT or in HALT SHALL return the block to RUN immediately and asynchronously, discarding the latch contents.

Verification
REQ-022 Case: ihit=1, memop=0, luh=0, redir=0 for 10 cycles -> all enables 1 every cycle, stall_cnt=0.
REQ-023 Case: mem_dREN=1 with ihit=1 at cycle 0, dhit=1 at cycle 3 -> enables 0 in cycles 0-2 and state WAIT; enables 1 in cycle 3; stall_cnt=3; ih_l cleared after cycle 3.
REQ-024 Case: ex_dREN=1, ex_regDst=5, id_rt=5, ihit=1 -> pc_en=0, ifid_en=0, idex_flush=1, exmem_en=1; with ex_regDst=0, no stall occurs.
REQ-025 Case: luh=1 and ex_branch_taken=1 in the same cycle, ihit=1 -> all enables 1, ifid_flush=idex_flush=1, stall_cnt unchanged.
REQ-026 Case: mem_halt=1 with adv=1 -> next cycle halt=1 and all enables 0 indefinitely; RST pulse -> halt=0, stall_cnt=0, state RUN.
REQ-027 Case: stall_cnt preloaded to 0xFFFE by 65534 stall cycles, then 3 more stall cycles -> stall_cnt holds at 0xFFFF.
